// File: rtl/hazard_forward_ctrl_pkg.sv
// pipe_ctrl_pkg: shared forwarding selects, controller state and register-zero constant
package pipe_ctrl_pkg;
   localparam logic [1:0] FWD_IDEX = 2'b00;
   localparam logic [1:0] FWD_WB   = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;
   localparam logic [4:0] REG_ZERO = 5'd0;
   typedef enum logic {RUN, STALLED} state_t;
endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// hazard_forward_ctrl_if: pipeline-register taps into the controller and its control/forward/counter outputs
// master: pipeline side driving register fields; slave: controller driving stalls, flushes, selects, counters
interface hazard_forward_ctrl_if #(parameter int CNT_W = 16);
   logic [4:0]       ID_RS, ID_RT, EX_RS, EX_RT, MEM_RegDst, WB_RegDst;
   logic             EX_MRead, MEM_RegWrite, MEM_Branch, MEM_Zero, WB_RegWrite;
   logic             PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush, EXMEM_Flush, PCSrc;
   logic [1:0]       ForwardA, ForwardB;
   logic [CNT_W-1:0] StallCount, FlushCount;
   modport master (
      output ID_RS, ID_RT, EX_MRead, EX_RS, EX_RT, MEM_RegWrite, MEM_RegDst, MEM_Branch, MEM_Zero,
             WB_RegWrite, WB_RegDst,
      input  PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush, EXMEM_Flush, PCSrc,
             ForwardA, ForwardB, StallCount, FlushCount
   );
   modport slave (
      input  ID_RS, ID_RT, EX_MRead, EX_RS, EX_RT, MEM_RegWrite, MEM_RegDst, MEM_Branch, MEM_Zero,
             WB_RegWrite, WB_RegDst,
      output PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush, EXMEM_Flush, PCSrc,
             ForwardA, ForwardB, StallCount, FlushCount
   );
endinterface

// File: rtl/hazard_forward_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
// clk/reset (async, active-high), inc: count this edge, count: current value
module sat_counter #(parameter int W = 16) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);
   always_ff @(posedge clk or posedge reset)
      if (reset) count <= '0;
      else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: load-use stall, taken-branch flush and EX operand forwarding for the 5-stage pipeline
// clk, reset (async, active-high), bus: pipeline register taps in, PC/register controls, forward selects, event counters out
module hazard_forward_ctrl
   import pipe_ctrl_pkg::*;
#(parameter int CNT_W = 16) (
   input logic                  clk,
   input logic                  reset,
   hazard_forward_ctrl_if.slave bus
);
   state_t state;
   logic   taken, hazard, stall;
   assign taken  = bus.MEM_Branch & bus.MEM_Zero;
   // detection is masked in STALLED so one load produces at most one bubble
   assign hazard = bus.EX_MRead && bus.EX_RT != REG_ZERO && (bus.EX_RT == bus.ID_RS || bus.EX_RT == bus.ID_RT)
                   && state == RUN;
   // a taken branch flushes the dependent instruction anyway, so it overrides the stall
   assign stall  = hazard & ~taken;
   assign bus.PCSrc       = taken;
   assign bus.IFID_Flush  = taken;
   assign bus.IDEX_Flush  = taken;
   assign bus.EXMEM_Flush = taken;
   assign bus.PCWrite     = ~stall;
   assign bus.IFID_Write  = ~stall;
   assign bus.IDEX_Bubble = stall;
   assign bus.ForwardA = (bus.MEM_RegWrite && bus.MEM_RegDst != REG_ZERO && bus.MEM_RegDst == bus.EX_RS) ? FWD_MEM :
                         (bus.WB_RegWrite && bus.WB_RegDst != REG_ZERO && bus.WB_RegDst == bus.EX_RS) ? FWD_WB : FWD_IDEX;
   assign bus.ForwardB = (bus.MEM_RegWrite && bus.MEM_RegDst != REG_ZERO && bus.MEM_RegDst == bus.EX_RT) ? FWD_MEM :
                         (bus.WB_RegWrite && bus.WB_RegDst != REG_ZERO && bus.WB_RegDst == bus.EX_RT) ? FWD_WB : FWD_IDEX;
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= RUN;
      else state <= stall ? STALLED : RUN;
   sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .reset(reset), .inc(stall), .count(bus.StallCount));
   sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .reset(reset), .inc(taken), .count(bus.FlushCount));
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl: directed and randomized checks of the controller against a behavioural model
module tb_hazard_forward_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;
   bit   chk_en = 1'b0;
   bit   m_stalled;
   int   m_sc, m_fc;
   int   sat_lit[5] = '{2, 3, 3, 3, 3};

   always #5 clk = ~clk;

   hazard_forward_ctrl_if #(.CNT_W(16)) b ();
   hazard_forward_ctrl_if #(.CNT_W(2))  bs ();
   hazard_forward_ctrl #(.CNT_W(16)) dut   (.clk(clk), .reset(reset), .bus(b));
   hazard_forward_ctrl #(.CNT_W(2))  dut_s (.clk(clk), .reset(reset), .bus(bs));

   assign bs.ID_RS        = b.ID_RS;
   assign bs.ID_RT        = b.ID_RT;
   assign bs.EX_MRead     = b.EX_MRead;
   assign bs.EX_RS        = b.EX_RS;
   assign bs.EX_RT        = b.EX_RT;
   assign bs.MEM_RegWrite = b.MEM_RegWrite;
   assign bs.MEM_RegDst   = b.MEM_RegDst;
   assign bs.MEM_Branch   = b.MEM_Branch;
   assign bs.MEM_Zero     = b.MEM_Zero;
   assign bs.WB_RegWrite  = b.WB_RegWrite;
   assign bs.WB_RegDst    = b.WB_RegDst;

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", n, act, exp, $time);
      end
   endtask

   task automatic idle();
      b.ID_RS = 0; b.ID_RT = 0; b.EX_MRead = 0; b.EX_RS = 0; b.EX_RT = 0;
      b.MEM_RegWrite = 0; b.MEM_RegDst = 0; b.MEM_Branch = 0; b.MEM_Zero = 0;
      b.WB_RegWrite = 0; b.WB_RegDst = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // reference: a newer producer (EX/MEM) beats an older one (MEM/WB); $0 is never a producer
   function automatic int fwd_exp(input int src);
      if (b.MEM_RegWrite && b.MEM_RegDst != 0 && b.MEM_RegDst == src) return 2;
      if (b.WB_RegWrite && b.WB_RegDst != 0 && b.WB_RegDst == src) return 1;
      return 0;
   endfunction

   function automatic bit taken_exp();
      return b.MEM_Branch && b.MEM_Zero;
   endfunction

   function automatic bit stall_exp();
      bit load_use;
      load_use = b.EX_MRead && b.EX_RT != 0 && (b.EX_RT == b.ID_RS || b.EX_RT == b.ID_RT) && !m_stalled;
      return load_use && !taken_exp();
   endfunction

   function automatic int clamp(input int v, input int mx);
      return v > mx ? mx : v;
   endfunction

   always @(posedge clk or posedge reset)
      if (reset) begin
         m_stalled = 0; m_sc = 0; m_fc = 0;
      end else begin
         if (taken_exp()) m_fc++;
         if (stall_exp()) m_sc++;
         m_stalled = stall_exp();
      end

   always @(negedge clk)
      if (chk_en) begin
         chk("PCWrite", b.PCWrite, !stall_exp());
         chk("IFID_Write", b.IFID_Write, !stall_exp());
         chk("IDEX_Bubble", b.IDEX_Bubble, stall_exp());
         chk("flushes", {b.IFID_Flush, b.IDEX_Flush, b.EXMEM_Flush}, taken_exp() ? 7 : 0);
         chk("PCSrc", b.PCSrc, taken_exp());
         chk("ForwardA", b.ForwardA, fwd_exp(b.EX_RS));
         chk("ForwardB", b.ForwardB, fwd_exp(b.EX_RT));
         chk("StallCount", b.StallCount, clamp(m_sc, 65535));
         chk("FlushCount", b.FlushCount, clamp(m_fc, 65535));
         chk("StallCount_w2", bs.StallCount, clamp(m_sc, 3));
         chk("FlushCount_w2", bs.FlushCount, clamp(m_fc, 3));
         chk("PCWrite_w2", bs.PCWrite, !stall_exp());
      end

   initial begin
      idle();
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      chk("reset_StallCount", b.StallCount, 0);
      chk("reset_FlushCount", b.FlushCount, 0);
      chk("reset_PCWrite", b.PCWrite, 1);
      reset = 1'b0;
      cyc();
      b.MEM_RegWrite = 1; b.MEM_RegDst = 8; b.WB_RegWrite = 1; b.WB_RegDst = 8; b.EX_RS = 8; b.EX_RT = 9;
      #1;
      chk("lit_fwdA_mem_priority", b.ForwardA, 2);
      chk("lit_fwdB_none", b.ForwardB, 0);
      b.WB_RegDst = 9;
      #1;
      chk("lit_fwdB_wb", b.ForwardB, 1);
      cyc();
      idle();
      b.MEM_RegWrite = 1; b.MEM_RegDst = 0; b.EX_RS = 0;
      #1;
      chk("lit_fwdA_r0", b.ForwardA, 0);
      cyc();
      idle();
      b.EX_MRead = 1; b.EX_RT = 0; b.ID_RS = 0;
      #1;
      chk("lit_r0_nostall", b.PCWrite, 1);
      cyc();
      idle();
      b.EX_MRead = 1; b.EX_RT = 5; b.ID_RT = 5;
      #1;
      chk("lit_lu_PCWrite", b.PCWrite, 0);
      chk("lit_lu_IFID_Write", b.IFID_Write, 0);
      chk("lit_lu_Bubble", b.IDEX_Bubble, 1);
      cyc();
      #1;
      chk("lit_stalled_PCWrite", b.PCWrite, 1);
      chk("lit_stalled_Bubble", b.IDEX_Bubble, 0);
      chk("lit_stalled_StallCount", b.StallCount, 1);
      reset = 1'b1;
      #1;
      chk("lit_rst_StallCount", b.StallCount, 0);
      chk("lit_rst_FlushCount", b.FlushCount, 0);
      chk("lit_rst_restall", b.PCWrite, 0);
      reset = 1'b0;
      cyc();
      idle();
      cyc();
      b.MEM_Branch = 1; b.MEM_Zero = 1; b.EX_MRead = 1; b.EX_RT = 5; b.ID_RS = 5;
      #1;
      chk("lit_br_PCSrc", b.PCSrc, 1);
      chk("lit_br_flushes", {b.IFID_Flush, b.IDEX_Flush, b.EXMEM_Flush}, 7);
      chk("lit_br_PCWrite", b.PCWrite, 1);
      chk("lit_br_Bubble", b.IDEX_Bubble, 0);
      cyc();
      #1;
      chk("lit_br_FlushCount", b.FlushCount, 1);
      chk("lit_br_StallCount", b.StallCount, 1);
      for (int i = 0; i < 5; i++) begin
         cyc();
         #1;
         chk("lit_sat_FlushCount_w2", bs.FlushCount, sat_lit[i]);
      end
      chk("lit_sat_FlushCount", b.FlushCount, 6);
      chk("lit_sat_StallCount_w2", bs.StallCount, 1);
      for (int i = 0; i < 3000; i++) begin
         cyc();
         b.ID_RS = 5'($urandom_range(0, 7));
         b.ID_RT = 5'($urandom_range(0, 7));
         b.EX_RS = 5'($urandom_range(0, 7));
         b.EX_RT = 5'($urandom_range(0, 7));
         b.MEM_RegDst = 5'($urandom_range(0, 7));
         b.WB_RegDst = 5'($urandom_range(0, 7));
         b.EX_MRead = 1'($urandom_range(0, 1));
         b.MEM_RegWrite = 1'($urandom_range(0, 1));
         b.WB_RegWrite = 1'($urandom_range(0, 1));
         b.MEM_Branch = 1'($urandom_range(0, 3) == 0);
         b.MEM_Zero = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 149) == 0) begin
            #1 reset = 1'b1;
            #1 reset = 1'b0;
         end
      end
      cyc();
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Hazard detection and forwarding controller for the five-stage MIPS pipeline. It reads the rs/rt fields leaving IF/ID and the control and destination outputs of PIPE_ID_EX, PIPE_EX_MEM and PIPE_MEM_WB. From these it drives the stall, write-enable, flush and bubble controls back into those registers and the PC. It also drives the forwarding mux selects for the EX-stage ALU inputs and keeps saturating stall and flush event counters for debug.

## Interface

Parameters:
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  pipeline clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- ID_RS  in  5  rs field of the instruction in ID.
- ID_RT  in  5  rt field of the instruction in ID.
- EX_MRead  in  1  MemRead control at the ID/EX output.
- EX_RS  in  5  rs at the ID/EX output.
- EX_RT  in  5  rt at the ID/EX output.
- MEM_RegWrite  in  1  RegWrite at the EX/MEM output.
- MEM_RegDst  in  5  destination register at the EX/MEM output.
- MEM_Branch  in  1  Branch at the EX/MEM output.
- MEM_Zero  in  1  Zero at the EX/MEM output.
- WB_RegWrite  in  1  RegWrite at the MEM/WB output.
- WB_RegDst  in  5  destination register at the MEM/WB output.
- PCWrite  out  1  PC update enable.
- IFID_Write  out  1  IF/ID load enable.
- IDEX_Bubble  out  1  zeroes all control bits entering ID/EX.
- IFID_Flush, IDEX_Flush, EXMEM_Flush  out  1 each  clear the contents of the named register on the next edge.
- PCSrc  out  1  selects the branch target for the PC.
- ForwardA, ForwardB  out  2 each  EX ALU operand selects.
- StallCount, FlushCount  out  CNT_W each  event counters.

## Operation

- Forwarding (combinational; shown for ForwardA using EX_RS, ForwardB is the same using EX_RT):
  - Select 2'b10 when MEM_RegWrite is high, MEM_RegDst ≠ 0 and MEM_RegDst = EX_RS.
  - Otherwise select 2'b01 when WB_RegWrite is high, WB_RegDst ≠ 0 and WB_RegDst = EX_RS.
  - Otherwise select 2'b00.
  - EX/MEM always has priority over MEM/WB.
- Branch taken: taken = MEM_Branch & MEM_Zero. PCSrc = taken.
- Load-use hazard: hazard = EX_MRead & (EX_RT ≠ 0) & (EX_RT = ID_RS | EX_RT = ID_RT) & (state = RUN).
- Priority:
  - When taken is high:
    - IFID_Flush = IDEX_Flush = EXMEM_Flush = 1.
    - PCWrite = 1, IFID_Write = 1, IDEX_Bubble = 0.
    - Any hazard is ignored.
  - Else when hazard is high: PCWrite = 0, IFID_Write = 0, IDEX_Bubble = 1, all flushes 0.
  - Else (normal): PCWrite = 1, IFID_Write = 1, IDEX_Bubble = 0, all flushes 0.
- State machine, 2 states:
  - RUN -> STALLED when hazard is high and taken is low.
  - STALLED -> RUN unconditionally. Load-use detection is masked in STALLED, so a stall never lasts more than one cycle.
  - Any state -> RUN when taken is high.
- Counters:
  - StallCount increments on each edge where a stall was issued that cycle.
  - FlushCount increments on each edge where taken was high.
  - Both saturate at 2^CNT_W − 1 and never wrap.

## Timing

- All control and forward outputs are combinational from the current inputs and the current state, with zero-cycle latency.
- State and counters update on the rising clk edge.
- Reset (asynchronous, active-high) forces:
  - state RUN;
  - StallCount and FlushCount to 0;
  - combinational outputs to the values for state RUN with the current inputs.
- Reset asserted mid-stall: state returns to RUN immediately, and a hazard still present on the inputs re-asserts the stall in the same cycle.
- Simultaneous taken branch and hazard: the flush wins, StallCount does not increment and FlushCount does.
- Both counters saturated: they hold their value, and control behaviour is unaffected.
- Register $0 never triggers forwarding or a stall.

## Structure

- Shared package `pipe_ctrl_pkg` holds:
  - forward select constants FWD_IDEX = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10;
  - the state enum (RUN, STALLED);
  - the REG_ZERO = 5'd0 constant.
- Sub-module `sat_counter` (parameter W; ports clk, reset, inc, count) is instantiated twice.
- Forwarding logic stays inline.

## Test plan

- Back-to-back ALU dependency:
  - Stimulus: MEM_RegWrite=1, MEM_RegDst=8, WB_RegWrite=1, WB_RegDst=8, EX_RS=8, EX_RT=9.
  - Required: ForwardA=10, ForwardB=00.
- Register $0:
  - Stimulus: MEM_RegWrite=1, MEM_RegDst=0, EX_RS=0.
  - Required: ForwardA=00.
  - Stimulus: EX_MRead=1, EX_RT=0, ID_RS=0.
  - Required: no stall.
- Load-use:
  - Stimulus: EX_MRead=1, EX_RT=5, ID_RT=5.
  - Required: PCWrite=0, IFID_Write=0, IDEX_Bubble=1 for exactly one cycle (inputs held). After the edge, state is STALLED with outputs normal, and StallCount=1.
- Taken branch with a simultaneous hazard:
  - Stimulus: MEM_Branch=1, MEM_Zero=1, EX_MRead=1, EX_RT=5, ID_RS=5.
  - Required: PCSrc=1, all three flushes=1, PCWrite=1, FlushCount increments by 1, StallCount unchanged.
- Saturation:
  - Setup: CNT_W=2.
  - Stimulus: five taken-branch cycles.
  - Required: FlushCount reaches 3 and holds at 3.
- Asynchronous reset between edges while in STALLED:
  - Required: counters read 0 immediately, state is RUN, and the stall re-asserts if the hazard inputs are still present.
